// File: rtl/spi_bus_arbiter_if.sv
// Requester-side and flash-side signal bundle for the SPI bus arbiter.
// The arbiter uses the slave modport; the requesters and flash model use master.
interface spi_bus_arbiter_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] m_clk;
    logic [1:0] m_cs_n;
    logic [1:0] m_mosi;
    logic [1:0] miso;
    logic       SPI_CLK;
    logic       SPI_CS_n;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic       busy;
    logic       hold_err;

    modport slave (
        input  req, m_clk, m_cs_n, m_mosi, SPI_MISO,
        output gnt, miso, SPI_CLK, SPI_CS_n, SPI_MOSI, busy, hold_err
    );

    modport master (
        output req, m_clk, m_cs_n, m_mosi, SPI_MISO,
        input  gnt, miso, SPI_CLK, SPI_CS_n, SPI_MOSI, busy, hold_err
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI flash pin set between two masters with transaction-granular
// ownership, a forced deselect gap between owners and a hold watchdog.
module spi_bus_arbiter #(
    parameter int unsigned DESELECT_CYCLES = 4,
    parameter int unsigned MAX_HOLD        = 4096
) (
    input  logic             clk,
    input  logic             IORST_n,
    spi_bus_arbiter_if.slave bus
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned GAP_W  = (DESELECT_CYCLES > 1) ? $clog2(DESELECT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN0,
        ARB_OWN1,
        ARB_GAP
    } arb_state_e;

    arb_state_e          state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                clk_q, clk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                own_idx;
    logic                pick;
    logic                release_c;
    logic                timeout_c;

    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            hold_q  <= '0;
            gap_q   <= '0;
            clk_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            clk_q   <= clk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Pins default to the idle values; only an owner that keeps the bus drives them.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        clk_d     = 1'b0;
        cs_n_d    = 1'b1;
        mosi_d    = 1'b0;
        err_d     = 1'b0;
        own_idx   = (state_q == ARB_OWN1);
        pick      = 1'b0;
        release_c = 1'b0;
        timeout_c = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (bus.req != 2'b00) begin
                    pick    = (bus.req == 2'b11) ? ~last_q : bus.req[1];
                    state_d = pick ? ARB_OWN1 : ARB_OWN0;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    hold_d  = '0;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                release_c = !bus.req[own_idx] && bus.m_cs_n[own_idx];
                timeout_c = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1));
                // A clean release in the watchdog cycle is not reported as an error.
                if (release_c || timeout_c) begin
                    state_d = ARB_GAP;
                    gnt_d   = 2'b00;
                    last_d  = own_idx;
                    gap_d   = GAP_W'(DESELECT_CYCLES - 1);
                    err_d   = !release_c;
                end else begin
                    clk_d   = bus.m_clk[own_idx];
                    cs_n_d  = bus.m_cs_n[own_idx];
                    mosi_d  = bus.m_mosi[own_idx];
                    if (hold_q != '1) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ARB_GAP: begin
                if (gap_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    assign bus.gnt      = gnt_q;
    assign bus.SPI_CLK  = clk_q;
    assign bus.SPI_CS_n = cs_n_q;
    assign bus.SPI_MOSI = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.hold_err = err_q;
    assign bus.miso     = {2{bus.SPI_MISO}};

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: vector table, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_spi_bus_arbiter;

    localparam int unsigned DES  = 4;
    localparam int unsigned MAXH = 16;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    spi_bus_arbiter_if bus ();
    spi_bus_arbiter_if bus2 ();

    spi_bus_arbiter #(.DESELECT_CYCLES(DES), .MAX_HOLD(MAXH)) u_dut (
        .clk     (clk),
        .IORST_n (rst_n),
        .bus     (bus)
    );

    spi_bus_arbiter #(.DESELECT_CYCLES(DES), .MAX_HOLD(0)) u_dut_nowd (
        .clk     (clk),
        .IORST_n (rst_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] cs_n;
        logic [1:0] mclk;
        logic [1:0] mosi;
        logic [1:0] e_gnt;
        logic       e_cs;
        logic       e_clk;
        logic       e_mosi;
        logic       e_busy;
    } vec_t;

    vec_t vecs[13];

    // Reference model state: owner index (-1 none), remaining deselect cycles,
    // cycles held by the current owner and the last owner for round robin.
    int         m_owner;
    int         m_cool;
    int         m_held;
    int         m_last;
    logic [1:0] e_gnt;
    logic       e_cs, e_clk, e_mosi, e_busy, e_err;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return 8'({bus.gnt, bus.SPI_CS_n, bus.SPI_CLK, bus.SPI_MOSI, bus.busy, bus.hold_err});
    endfunction

    task automatic drive(input logic [1:0] r, input logic [1:0] cs, input logic [1:0] mc,
                         input logic [1:0] mo);
        bus.req    = r;
        bus.m_cs_n = cs;
        bus.m_clk  = mc;
        bus.m_mosi = mo;
    endtask

    task automatic step(input logic [1:0] r, input logic [1:0] cs, input logic [1:0] mc,
                        input logic [1:0] mo);
        drive(r, cs, mc, mo);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 2'b11, 2'b00, 2'b00);
        bus.SPI_MISO = 1'b0;
        bus2.req = 2'b00; bus2.m_cs_n = 2'b11; bus2.m_clk = 2'b00; bus2.m_mosi = 2'b00;
        bus2.SPI_MISO = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_owner = -1; m_cool = 0; m_held = 0; m_last = 1;
        e_gnt = 2'b00; e_cs = 1'b1; e_clk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] r, input logic [1:0] cs, input logic [1:0] mc,
                              input logic [1:0] mo);
        bit rel, tmo;
        e_err = 1'b0; e_cs = 1'b1; e_clk = 1'b0; e_mosi = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            rel = !r[m_owner] && cs[m_owner];
            tmo = (MAXH != 0) && (m_held >= int'(MAXH)) && !rel;
            if (rel || tmo) begin
                m_last = m_owner; m_owner = -1; m_cool = DES; e_gnt = 2'b00; e_err = tmo;
            end else begin
                e_cs = cs[m_owner]; e_clk = mc[m_owner]; e_mosi = mo[m_owner];
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 2'b00) begin
            if (r == 2'b11) m_owner = 1 - m_last;
            else            m_owner = r[0] ? 0 : 1;
            m_held = 0;
            e_gnt = (m_owner == 1) ? 2'b10 : 2'b01;
        end
        e_busy = (m_owner >= 0) || (m_cool > 0);
    endtask

    initial begin
        logic [1:0] rr, rc, rk, rm;
        bit         bad;
        checks = 0;
        errors = 0;

        //                req    cs_n   mclk   mosi   gnt   cs    clk   mosi  busy
        vecs[0]  = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{2'b01, 2'b00, 2'b01, 2'b11, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values
        do_reset();
        chk("reset_outputs", outs(), 8'b00_1_0_0_0_0);

        // Vector table: grant latency, pin pass-through, held grant, gap length
        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].cs_n, vecs[i].mclk, vecs[i].mosi);
            chk($sformatf("vec%0d", i), outs(),
                8'({vecs[i].e_gnt, vecs[i].e_cs, vecs[i].e_clk, vecs[i].e_mosi, vecs[i].e_busy, 1'b0}));
        end

        // Round robin with both requesting
        do_reset();
        step(2'b11, 2'b11, 2'b00, 2'b00);
        chk("rr_first_gnt", 8'(bus.gnt), 8'b01);
        step(2'b10, 2'b11, 2'b00, 2'b00);
        chk("rr_release0", 8'(bus.gnt), 8'b00);
        for (int k = 0; k < int'(DES); k++) begin
            step(2'b11, 2'b11, 2'b00, 2'b00);
            chk($sformatf("rr_gap0_%0d", k), 8'(bus.gnt), 8'b00);
        end
        step(2'b11, 2'b11, 2'b00, 2'b00);
        chk("rr_second_gnt", 8'(bus.gnt), 8'b10);
        step(2'b01, 2'b11, 2'b00, 2'b00);
        chk("rr_release1", 8'(bus.gnt), 8'b00);
        repeat (DES) step(2'b11, 2'b11, 2'b00, 2'b00);
        step(2'b11, 2'b11, 2'b00, 2'b00);
        chk("rr_third_gnt", 8'(bus.gnt), 8'b01);

        // Watchdog on owner 1 with owner 0 waiting
        do_reset();
        step(2'b10, 2'b01, 2'b00, 2'b00);
        chk("wd_gnt", 8'(bus.gnt), 8'b10);
        for (int k = 2; k <= int'(MAXH); k++) begin
            step(2'b11, 2'b01, 2'b00, 2'b00);
            chk($sformatf("wd_hold_%0d", k), outs(), 8'b10_0_0_0_1_0);
        end
        step(2'b11, 2'b01, 2'b00, 2'b00);
        chk("wd_fire", outs(), 8'b00_1_0_0_1_1);
        step(2'b11, 2'b01, 2'b00, 2'b00);
        chk("wd_pulse_end", outs(), 8'b00_1_0_0_1_0);
        repeat (DES - 1) step(2'b11, 2'b01, 2'b00, 2'b00);
        chk("wd_gap_end", 8'(bus.gnt), 8'b00);
        step(2'b11, 2'b01, 2'b00, 2'b00);
        chk("wd_next_owner", 8'(bus.gnt), 8'b01);

        // Asynchronous reset mid-byte
        do_reset();
        step(2'b01, 2'b10, 2'b01, 2'b01);
        step(2'b01, 2'b10, 2'b01, 2'b01);
        chk("ar_active", outs(), 8'b01_0_1_1_1_0);
        #2 rst_n = 1'b0;
        #1 chk("ar_async", outs(), 8'b00_1_0_0_0_0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b10, 2'b11, 2'b00, 2'b00);
        chk("ar_regrant", 8'(bus.gnt), 8'b10);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        rr = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) rr[0] = ~rr[0];
            if ($urandom_range(7) == 0) rr[1] = ~rr[1];
            rc[0] = ($urandom_range(3) != 0);
            rc[1] = ($urandom_range(3) != 0);
            rk = 2'($urandom);
            rm = 2'($urandom);
            drive(rr, rc, rk, rm);
            bus.SPI_MISO = 1'($urandom);
            @(posedge clk);
            model_edge(rr, rc, rk, rm);
            @(negedge clk);
            chk($sformatf("rand_%0d", n), outs(),
                8'({e_gnt, e_cs, e_clk, e_mosi, e_busy, e_err}));
            chk($sformatf("rand_miso_%0d", n), 8'(bus.miso), 8'({2{bus.SPI_MISO}}));
        end

        // Watchdog disabled: a long hold never times out
        do_reset();
        bus2.req = 2'b01; bus2.m_cs_n = 2'b10;
        bad = 1'b0;
        for (int b = 0; b < 10; b++) begin
            repeat (1000) begin
                @(negedge clk);
                if (bus2.hold_err !== 1'b0) bad = 1'b1;
            end
            chk($sformatf("nowd_block_%0d", b), 8'({bad, bus2.gnt}), 8'b0_01);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
